dac_write_sched: RTL and testbench
==================================

// Module: dac_write_sched
// PURPOSE
//  Two-requester write scheduler for the AD7302 dual 8-bit DAC. Arbitrates channel-A and channel-B
//  sources round-robin, drives DAC_D / DAC_A_B / DAC_WRN with programmable setup, pulse and hold timing,
//  and returns a one-cycle ack per accepted write. Sits between the value/waveform generators and DAC pins.
// PARAMETERS
//  SETUP_CYC  2  cycles DAC_D/DAC_A_B stable (WRN high) before WRN falls; range 1..255
//  PULSE_CYC  3  cycles WRN held low; range 1..255
//  HOLD_CYC   2  cycles DAC_D/DAC_A_B held after WRN rises; range 1..255
// PORTS
//  clk        in   1  system clock, 50 MHz
//  rst_n      in   1  asynchronous reset, active low
//  req_a      in   1  channel-A write request, level; hold with data_a stable until ack_a
//  data_a     in   8  channel-A code
//  ack_a      out  1  one-cycle pulse: data_a captured
//  req_b      in   1  channel-B write request, level
//  data_b     in   8  channel-B code
//  ack_b      out  1  one-cycle pulse: data_b captured
//  DAC_D      out  8  DAC data bus
//  DAC_A_B    out  1  channel select, 0 = A, 1 = B
//  DAC_WRN    out  1  DAC write strobe, active low; DAC latches on rising edge
//  busy       out  1  high whenever state != IDLE
// BEHAVIOUR
//  Reset: DAC_D=0, DAC_A_B=0, DAC_WRN=1, ack_a=ack_b=0, busy=0, state=IDLE, last_grant=B (A wins first).
//  FSM IDLE -> SETUP -> PULSE -> HOLD -> IDLE. An 8-bit down-counter loads N-1 on entry to each timed state.
//  IDLE, cycle T0 with any req sampled high: grant. At edge ending T0: DAC_D<=granted data,
//   DAC_A_B<=granted channel, ack of granted channel=1 for cycle T1 only, state<=SETUP.
//  SETUP lasts SETUP_CYC cycles (WRN=1); PULSE lasts PULSE_CYC cycles (WRN=0); HOLD lasts HOLD_CYC (WRN=1).
//  DAC_D/DAC_A_B constant from T1 until the next grant; WRN falls at T1+SETUP_CYC, rises at T1+SETUP_CYC+PULSE_CYC.
//  HOLD's final cycle returns to IDLE; IDLE may grant in its first cycle. Write period = 1+SETUP+PULSE+HOLD cycles (8 default).
//  Arbitration: only one req -> it wins; both -> channel != last_grant wins; last_grant updates on grant only.
//  req deasserted before grant: no write, no ack. req held after ack: treated as a new request (re-written).
//  Requests arriving while busy wait; no queuing beyond the level req.
//  Reset mid-transfer: WRN forced high immediately (async); partial write is permitted, not corrected.
// CONFIGURATION
//  DAC_SYNC_LOAD_EN defined: adds ports load_req (in, 1, pulse) and DAC_LDAC_N (out, 1, reset 1).
//   load_req sets a pending flag (sticky while busy); in IDLE pending load beats pending writes:
//   state LOAD drives DAC_LDAC_N=0 for PULSE_CYC cycles, then IDLE, flag cleared. Load and req in the same
//   IDLE cycle: LOAD first, write granted after. load_req during LOAD re-arms the flag.
//  Not defined: no LOAD state, no load ports; LDAC is tied low on the board (DAC transparent).
// STRUCTURE
//  Package dac_ctrl_pkg: state enum (IDLE, SETUP, PULSE, HOLD, LOAD), CH_A=1'b0, CH_B=1'b1, CNT_W=8.
//  Sub-module dac_rr_arbiter: 2-way round-robin grant, inputs req_a/req_b/last_grant/en, outputs gnt_a/gnt_b.
//  Top holds FSM, timing counter, output registers, optional load flag.
// TESTING
//  Reset: after rst_n release, DAC_WRN=1, DAC_D=0, busy=0, no ack for 10 cycles with reqs low.
//  Single A write data_a=8'h5A: ack_a 1 cycle; DAC_A_B=0, DAC_D=5A; WRN low exactly 3 cycles after 2 setup; busy 7 cycles.
//  req_a and req_b held high together (A=10,B=20): writes alternate A,B,A,B; acks alternate; 8-cycle period.
//  SETUP_CYC=1,PULSE_CYC=1,HOLD_CYC=1: WRN low 1 cycle; back-to-back writes every 4 cycles.
//  rst_n asserted during PULSE: DAC_WRN=1 same cycle (async), state IDLE, acks 0.
//  DAC_SYNC_LOAD_EN: load_req during B write -> DAC_LDAC_N low 3 cycles after HOLD, before pending req_a granted.

Source files
------------

// File: rtl/dac_ctrl_pkg.sv
// Shared types and constants for the AD7302 write scheduler.
// The LOAD state is only reachable when DAC_SYNC_LOAD_EN is defined.
package dac_ctrl_pkg;

    localparam int CNT_W = 8;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        LOAD
    } state_e;

    typedef struct packed {
        logic       req;
        logic [7:0] data;
    } wr_req_t;

    // Down-counter reload value for a state lasting n cycles.
    function automatic logic [CNT_W-1:0] cyc_ld(input int n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/dac_rr_arbiter.sv
// Two-way round-robin grant: a lone request wins, on contention the
// channel that did not win last time goes next.
module dac_rr_arbiter
    import dac_ctrl_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_grant,
    input  logic en,
    output logic gnt_a,
    output logic gnt_b
);

    assign gnt_a = en & req_a & (~req_b | (last_grant == CH_B));
    assign gnt_b = en & req_b & (~req_a | (last_grant == CH_A));

endmodule

// File: rtl/dac_write_sched.sv
// AD7302 dual-DAC write scheduler: arbitrates A/B writers and sequences DAC_WRN.
// Optional DAC_SYNC_LOAD_EN adds load_req / DAC_LDAC_N synchronous-load support.
module dac_write_sched
    import dac_ctrl_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 3,
    parameter int HOLD_CYC  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_a,
    input  logic [7:0] data_a,
    output logic       ack_a,
    input  logic       req_b,
    input  logic [7:0] data_b,
    output logic       ack_b,
    output logic [7:0] DAC_D,
    output logic       DAC_A_B,
    output logic       DAC_WRN,
`ifdef DAC_SYNC_LOAD_EN
    input  logic       load_req,
    output logic       DAC_LDAC_N,
`endif
    output logic       busy
);

    localparam logic [CNT_W-1:0] SETUP_LD = cyc_ld(SETUP_CYC);
    localparam logic [CNT_W-1:0] PULSE_LD = cyc_ld(PULSE_CYC);
    localparam logic [CNT_W-1:0] HOLD_LD  = cyc_ld(HOLD_CYC);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q;
    logic             gnt_a, gnt_b, arb_en, load_go;
    wr_req_t          src_a, src_b;

    assign src_a = '{req: req_a, data: data_a};
    assign src_b = '{req: req_b, data: data_b};

`ifdef DAC_SYNC_LOAD_EN
    logic load_pend_q;
    // A load seen in the same IDLE cycle as a write request still goes first.
    assign load_go = (state_q == IDLE) & (load_pend_q | load_req);
`else
    assign load_go = 1'b0;
`endif

    assign arb_en = (state_q == IDLE) & ~load_go;
    assign busy   = (state_q != IDLE);

    dac_rr_arbiter u_arb (
        .req_a      (src_a.req),
        .req_b      (src_b.req),
        .last_grant (last_q),
        .en         (arb_en),
        .gnt_a      (gnt_a),
        .gnt_b      (gnt_b)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (load_go) begin
                    state_d = LOAD;
                    cnt_d   = PULSE_LD;
                end else if (gnt_a | gnt_b) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LD;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD, LOAD: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are registered from next state so the pins never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= CH_B;
            DAC_D   <= '0;
            DAC_A_B <= CH_A;
            DAC_WRN <= 1'b1;
            ack_a   <= 1'b0;
            ack_b   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_a   <= gnt_a;
            ack_b   <= gnt_b;
            DAC_WRN <= (state_d != PULSE);
            if (gnt_a | gnt_b) begin
                DAC_D   <= gnt_a ? src_a.data : src_b.data;
                DAC_A_B <= gnt_a ? CH_A : CH_B;
                last_q  <= gnt_a ? CH_A : CH_B;
            end
        end
    end

`ifdef DAC_SYNC_LOAD_EN
    // Flag clears on entry to LOAD; a load_req during LOAD arms it again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_pend_q <= 1'b0;
            DAC_LDAC_N  <= 1'b1;
        end else begin
            load_pend_q <= load_go ? 1'b0 : (load_pend_q | load_req);
            DAC_LDAC_N  <= (state_d != LOAD);
        end
    end
`endif

endmodule

// File: tb/tb_dac_write_sched.sv
// Self-checking bench for dac_write_sched: vector table plus scoreboard of expected writes.
`timescale 1ns/1ps
module tb_dac_write_sched;
    import dac_ctrl_pkg::*;

    localparam int S = 2, P = 3, H = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req_a, req_b, ack_a, ack_b, DAC_A_B, DAC_WRN, busy;
    logic [7:0] data_a, data_b, DAC_D;
    logic       req_a1, req_b1, ack_a1, ack_b1, ab1, wrn1, busy1;
    logic [7:0] data_a1, data_b1, d1;
    logic       load_req, ldac_n, load_req1, ldac_n1;

    dac_write_sched #(.SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
        .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
        .DAC_D(DAC_D), .DAC_A_B(DAC_A_B), .DAC_WRN(DAC_WRN),
`ifdef DAC_SYNC_LOAD_EN
        .load_req(load_req), .DAC_LDAC_N(ldac_n),
`endif
        .busy(busy)
    );

    dac_write_sched #(.SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a1), .data_a(data_a1), .ack_a(ack_a1),
        .req_b(req_b1), .data_b(data_b1), .ack_b(ack_b1),
        .DAC_D(d1), .DAC_A_B(ab1), .DAC_WRN(wrn1),
`ifdef DAC_SYNC_LOAD_EN
        .load_req(load_req1), .DAC_LDAC_N(ldac_n1),
`endif
        .busy(busy1)
    );

`ifndef DAC_SYNC_LOAD_EN
    assign ldac_n  = 1'b1;
    assign ldac_n1 = 1'b1;
`endif

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed { logic ch; logic [7:0] d; } exp_t;
    exp_t sb[$];

    typedef struct {
        bit ra; bit rb; logic [7:0] da; logic [7:0] db;
        logic exp_ch; logic [7:0] exp_d;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic wait_ack(output bit seen, input int lim);
        seen = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (ack_a | ack_b) begin seen = 1; break; end
        end
        if (!seen) chk("ack_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        chk("idle_timeout", 1, 0);
    endtask

    // Monitor on the default-timing instance: scoreboard pops and pin timing.
    bit   per_chk = 0, prev_wrn = 1, load_seen = 0;
    int   t_ack = -1, t_fall = -1, per_ack = -1, bcnt = 0;
    exp_t e;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_wrn = 1; t_ack = -1; t_fall = -1; per_ack = -1; bcnt = 0; load_seen = 0;
        end else begin
            if (ack_a | ack_b) begin
                if (sb.size() == 0) chk("unexpected_ack", {ack_a, ack_b}, 0);
                else begin
                    e = sb.pop_front();
                    chk("ack_chan", {ack_a, ack_b}, e.ch ? 2'b01 : 2'b10);
                    chk("dac_a_b", DAC_A_B, e.ch);
                    chk("dac_d", DAC_D, e.d);
                end
                if (per_chk && per_ack >= 0) chk("write_period", cyc - per_ack, 1 + S + P + H);
                if (per_chk) per_ack = cyc;
                t_ack = cyc;
            end
            if (prev_wrn && !DAC_WRN) begin chk("setup_len", cyc - t_ack, S); t_fall = cyc; end
            if (!prev_wrn && DAC_WRN) chk("pulse_len", cyc - t_fall, P);
            if (!ldac_n) load_seen = 1;
            if (busy) bcnt++;
            else if (bcnt != 0) begin
                chk("busy_len", bcnt, load_seen ? P : S + P + H);
                bcnt = 0; load_seen = 0;
            end
            prev_wrn = DAC_WRN;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int n, lcnt;
        rst_n = 0; req_a = 0; req_b = 0; data_a = 0; data_b = 0;
        req_a1 = 0; req_b1 = 0; data_a1 = 0; data_b1 = 0; load_req = 0; load_req1 = 0;

        // Reset leaves last_grant = B, so contention resolves A, B, A, ...
        vecs[0] = '{1, 0, 8'h5A, 8'h00, CH_A, 8'h5A};
        vecs[1] = '{0, 1, 8'h00, 8'h3C, CH_B, 8'h3C};
        vecs[2] = '{1, 1, 8'h11, 8'h22, CH_A, 8'h11};
        vecs[3] = '{1, 1, 8'h33, 8'h44, CH_B, 8'h44};
        vecs[4] = '{1, 0, 8'h00, 8'hAA, CH_A, 8'h00};
        vecs[5] = '{0, 1, 8'h12, 8'hFF, CH_B, 8'hFF};
        vecs[6] = '{1, 1, 8'h80, 8'h7F, CH_A, 8'h80};

        repeat (3) @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("reset_state", {DAC_WRN, busy, ack_a, ack_b, DAC_D, DAC_A_B, ldac_n},
                {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1});
        end

        foreach (vecs[i]) begin
            req_a = vecs[i].ra; data_a = vecs[i].da;
            req_b = vecs[i].rb; data_b = vecs[i].db;
            sb.push_back('{vecs[i].exp_ch, vecs[i].exp_d});
            wait_ack(seen, 20);
            req_a = 0; req_b = 0;
            wait_idle(20);
        end

        // Both held: last grant was A, so B leads and channels alternate.
        per_chk = 1; per_ack = -1;
        req_a = 1; data_a = 8'h10; req_b = 1; data_b = 8'h20;
        sb.push_back('{CH_B, 8'h20}); sb.push_back('{CH_A, 8'h10});
        sb.push_back('{CH_B, 8'h20}); sb.push_back('{CH_A, 8'h10});
        for (int k = 0; k < 4; k++) wait_ack(seen, 20);
        req_a = 0; req_b = 0;
        wait_idle(20);
        per_chk = 0;

        // Request withdrawn before the grant edge: no write.
        req_a = 1; data_a = 8'hEE;
        #2 req_a = 0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n += int'(ack_a | ack_b | busy);
        end
        chk("drop_no_write", n, 0);

        // Asynchronous reset during the WRN pulse.
        req_b = 1; data_b = 8'h99;
        sb.push_back('{CH_B, 8'h99});
        wait_ack(seen, 20);
        req_b = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!DAC_WRN) break;
        end
        chk("wrn_low_before_rst", DAC_WRN, 0);
        #1 rst_n = 0;
        #1 chk("async_reset", {DAC_WRN, busy, ack_a, ack_b, DAC_D}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        @(negedge clk); @(negedge clk);
        rst_n = 1;

        // Minimum timing instance, both requesters held: one write every 4 cycles.
        req_a1 = 1; data_a1 = 8'hA1; req_b1 = 1; data_b1 = 8'hB1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack_a1) begin seen = 1; break; end
        end
        chk("t111_first_ack", seen, 1);
        if (seen) begin
            for (int i = 0; i < 12; i++) begin
                if (i > 0) @(negedge clk);
                chk("t111_pins", {ack_a1, ack_b1, wrn1}, {i % 8 == 0, i % 8 == 4, i % 4 != 1});
                chk("t111_data", {ab1, d1}, (i % 8 < 4) ? {CH_A, 8'hA1} : {CH_B, 8'hB1});
            end
        end
        req_a1 = 0; req_b1 = 0;
        repeat (4) @(negedge clk);

`ifdef DAC_SYNC_LOAD_EN
        // Load requested during a B write runs before the waiting A write.
        req_b = 1; data_b = 8'h55;
        sb.push_back('{CH_B, 8'h55});
        wait_ack(seen, 20);
        req_b = 0;
        @(negedge clk); load_req = 1;
        @(negedge clk); load_req = 0;
        req_a = 1; data_a = 8'h66;
        sb.push_back('{CH_A, 8'h66});
        lcnt = 0; seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!ldac_n) lcnt++;
            if (ack_a) begin seen = 1; break; end
        end
        req_a = 0;
        chk("ldac_len", lcnt, P);
        chk("ldac_before_a", seen, 1);
        wait_idle(20);
`endif

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
